dff_lane_bank: RTL and testbench
================================

// Module: dff_lane_bank
// PURPOSE
//   Parametrised bank of LANES independently-enabled D flip-flop lanes, LANE_W bits each.
//   Each lane loads on its own enable with no effect on other lanes; a synchronous reset
//   restores all lanes to a known value.
//   An optional shadow path stages lane writes and applies them atomically on COMMIT.
//   Used as a synthesis-regression target for per-lane enabled DFF inference.
// PARAMETERS
//   LANES     4    number of independently enabled lanes (>=1)
//   LANE_W    1    bits per lane (>=1)
//   RESET_VAL 0    value of Q after reset, LANES*LANE_W bits, lane i = bits [i*LANE_W +: LANE_W]
//   CNT_W     4    width of COMMIT_CNT (shadow build only)
// PORTS
//   CLK         in   1              clock, all state updates on posedge
//   RST         in   1              synchronous, active-high reset
//   EN          in   LANES          per-lane load enable, EN[i] controls lane i
//   D           in   LANES*LANE_W   data in, lane-packed
//   COMMIT      in   1              apply staged lanes (shadow build; ignored otherwise)
//   Q           out  LANES*LANE_W   registered lane outputs
//   PENDING     out  LANES          lane staged but not committed (0 without shadow)
//   COMMIT_CNT  out  CNT_W          count of effective commits (0 without shadow)
// BEHAVIOUR
//   - All state is reset only by RST, sampled at posedge CLK. RST has priority over EN and COMMIT.
//   - Before the first reset, Q is X; lanes never written and never reset stay X.
//   - On reset: Q=RESET_VAL, PENDING=0, COMMIT_CNT=0, staging=RESET_VAL.
//   - Direct mode (macro absent):
//     - Lane i: if EN[i], then Q lane i <= D lane i. Otherwise Q lane i holds.
//     - Latency is 1 cycle.
//     - Lanes are fully independent: any EN pattern, including all-ones or all-zero, is legal.
//   - Shadow mode (macro present):
//     - EN[i] & !COMMIT: staging lane i <= D lane i; PENDING[i] <= 1; Q holds.
//     - COMMIT: for every lane with PENDING[i] or EN[i]:
//       - Q lane i <= (EN[i] ? D lane i : staging lane i).
//       - Same-cycle EN bypasses staging.
//       - Staging lane i is also updated when EN[i].
//     - COMMIT: PENDING <= 0.
//     - COMMIT_CNT increments by 1 (wrapping mod 2**CNT_W) iff at least one lane was applied.
//     - COMMIT with no pending lanes and EN=0 is a no-op; COMMIT_CNT does not change.
//     - Repeated EN to a lane before COMMIT: the last write wins.
//     - RST mid-staging discards all pending lanes.
//   - Widths: D and Q slices never overlap. Out-of-range lanes do not exist, because the
//     EN width equals LANES.
// CONFIGURATION
//   DFF_LANE_BANK_SHADOW_EN
//     - Defined: staging registers, PENDING tracking, COMMIT and COMMIT_CNT are built as above.
//     - Undefined: direct mode only. PENDING and COMMIT_CNT are tied to 0, and COMMIT is unused.
// STRUCTURE
//   - Package dff_lane_bank_pkg holds:
//     - the lane_slice helper, giving bit offset i*LANE_W;
//     - the default CNT_W constant;
//     - the lane-mask typedef used by the bench for EN and PENDING patterns.
//   - Sub-module dff_lane_bank_lane (one lane: Q, optional staging and pending bit) is
//     instantiated LANES times in a generate loop.
//   - COMMIT_CNT and the any-lane-applied OR reduction live in the top module.
// TESTING (LANES=4, LANE_W=1, RESET_VAL=0)
//   1. No RST, EN=0000, one clock -> Q===4'bxxxx.
//      Then EN=0010, D=0000, clock -> Q===4'bxx0x (lane 1 only).
//   2. EN=0100, D=1111, clock -> Q===4'bx10x.
//      Then EN=1000, D=0000, clock -> Q===4'b010x. Unenabled lanes stay untouched.
//   3. RST=1 together with EN=1111, D=1111, clock -> Q=0000. RST wins.
//      Then EN=1111, D=1010, clock -> Q=1010.
//   4. Shadow build:
//      - EN=0001, D=0001, clock -> Q=0000, PENDING=0001.
//      - COMMIT=1, EN=0100, D=0100, clock -> Q=0101, PENDING=0000, COMMIT_CNT=1.
//   5. Shadow build:
//      - COMMIT with PENDING=0 and EN=0 -> Q and COMMIT_CNT unchanged.
//      - Stage lane 2 twice (D=0100, then D=0000), then commit -> lane 2 = 0.
//   6. Shadow build:
//      - Stage EN=1111, D=1111, then RST -> PENDING=0.
//      - A following COMMIT leaves Q=RESET_VAL.
//      - 2**CNT_W effective commits -> COMMIT_CNT wraps to 0.

Source files
------------

// File: rtl/dff_lane_bank_pkg.sv
// dff_lane_bank_pkg: shared constants, lane slicing helper and lane-mask type for dff_lane_bank
package dff_lane_bank_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int LANES_DEF = 4;
  typedef logic [LANES_DEF-1:0] lane_mask_t;
  function automatic int lane_slice(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/dff_lane_bank_if.sv
// dff_lane_bank_if: lane enables, lane-packed data, commit strobe and lane bank outputs
interface dff_lane_bank_if
  import dff_lane_bank_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = 1,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [LANES-1:0]        EN;
  logic [LANES*LANE_W-1:0] D;
  logic                    COMMIT;
  logic [LANES*LANE_W-1:0] Q;
  logic [LANES-1:0]        PENDING;
  logic [CNT_W-1:0]        COMMIT_CNT;
  modport master (output EN, D, COMMIT, input Q, PENDING, COMMIT_CNT);
  modport slave (input EN, D, COMMIT, output Q, PENDING, COMMIT_CNT);
endinterface

// File: rtl/dff_lane_bank_lane.sv
// dff_lane_bank_lane: one enabled DFF lane; with DFF_LANE_BANK_SHADOW_EN it adds a staging register and pending bit
module dff_lane_bank_lane #(
  parameter int                LANE_W    = 1,
  parameter logic [LANE_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [LANE_W-1:0] d,
  input  logic              commit,
  output logic [LANE_W-1:0] q,
  output logic              pending
);
`ifdef DFF_LANE_BANK_SHADOW_EN
  logic [LANE_W-1:0] stg;
  logic              pend;
  // stage writes; on commit apply staged or same-cycle data and clear pending
  always_ff @(posedge CLK)
    if (RST) begin
      q    <= RESET_VAL;
      stg  <= RESET_VAL;
      pend <= 1'b0;
    end else begin
      if (en) stg <= d;
      if (commit && (pend || en)) q <= en ? d : stg;
      pend <= commit ? 1'b0 : pend | en;
    end
  assign pending = pend;
`else
  logic unused_commit;
  // direct load on enable, hold otherwise
  always_ff @(posedge CLK)
    if (RST) q <= RESET_VAL;
    else if (en) q <= d;
  assign pending       = 1'b0;
  assign unused_commit = commit;
`endif
endmodule

// File: rtl/dff_lane_bank.sv
// dff_lane_bank: LANES independently enabled DFF lanes; DFF_LANE_BANK_SHADOW_EN enables staged atomic commit
module dff_lane_bank
  import dff_lane_bank_pkg::*;
#(
  parameter int                       LANES     = LANES_DEF,
  parameter int                       LANE_W    = 1,
  parameter logic [LANES*LANE_W-1:0]  RESET_VAL = '0,
  parameter int                       CNT_W     = CNT_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  dff_lane_bank_if.slave bus
);
  logic [LANES-1:0] pend;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dff_lane_bank_lane #(
      .LANE_W   (LANE_W),
      .RESET_VAL(RESET_VAL[lane_slice(i, LANE_W) +: LANE_W])
    ) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .en     (bus.EN[i]),
      .d      (bus.D[lane_slice(i, LANE_W) +: LANE_W]),
      .commit (bus.COMMIT),
      .q      (bus.Q[lane_slice(i, LANE_W) +: LANE_W]),
      .pending(pend[i])
    );
  end
  assign bus.PENDING = pend;
`ifdef DFF_LANE_BANK_SHADOW_EN
  logic [CNT_W-1:0] cnt;
  logic             any_applied;
  assign any_applied = bus.COMMIT & |(pend | bus.EN);
  // count only commits that moved at least one lane
  always_ff @(posedge CLK)
    cnt <= RST ? '0 : cnt + CNT_W'(any_applied);
  assign bus.COMMIT_CNT = cnt;
`else
  assign bus.COMMIT_CNT = '0;
`endif
endmodule

// File: tb/tb_dff_lane_bank.sv
// tb_dff_lane_bank: scoreboard bench for dff_lane_bank, direct or DFF_LANE_BANK_SHADOW_EN build
module tb_dff_lane_bank;
  import dff_lane_bank_pkg::*;
  typedef struct {
    lane_mask_t q;
    lane_mask_t m;
    lane_mask_t p;
    logic [3:0] c;
  } exp_t;
  logic CLK = 1'b0;
  logic RST;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  dff_lane_bank_if #(.LANES(4), .LANE_W(1), .CNT_W(4)) bus ();
  dff_lane_bank #(.LANES(4), .LANE_W(1), .RESET_VAL(4'b0000), .CNT_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic step(input logic r, input lane_mask_t en, input lane_mask_t d, input logic c,
                      input lane_mask_t eq, input lane_mask_t em, input lane_mask_t ep,
                      input logic [3:0] ec);
    exp_t e;
    @(negedge CLK);
    RST        = r;
    bus.EN     = en;
    bus.D      = d;
    bus.COMMIT = c;
    e.q = eq;
    e.m = em;
    e.p = ep;
    e.c = ec;
    sb.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (((bus.Q ^ e.q) & e.m) !== 4'b0000) begin
          errors++;
          $display("FAIL q: got %b want %b (known lanes %b)", bus.Q, e.q, e.m);
        end
        checks++;
        if (bus.PENDING !== e.p) begin
          errors++;
          $display("FAIL pending: got %b want %b", bus.PENDING, e.p);
        end
        checks++;
        if (bus.COMMIT_CNT !== e.c) begin
          errors++;
          $display("FAIL commit_cnt: got %0d want %0d", bus.COMMIT_CNT, e.c);
        end
      end
    end
  end
  initial begin
    int guard;
    RST        = 1'b0;
    bus.EN     = 4'b0000;
    bus.D      = 4'b0000;
    bus.COMMIT = 1'b0;
`ifdef DFF_LANE_BANK_SHADOW_EN
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b0001, 4'b0001, 0, 4'b0000, 4'b1111, 4'b0001, 4'd0);
    step(0, 4'b0100, 4'b0100, 1, 4'b0101, 4'b1111, 4'b0000, 4'd1);
    step(0, 4'b0000, 4'b1111, 1, 4'b0101, 4'b1111, 4'b0000, 4'd1);
    step(0, 4'b0100, 4'b0100, 0, 4'b0101, 4'b1111, 4'b0100, 4'd1);
    step(0, 4'b0100, 4'b0000, 0, 4'b0101, 4'b1111, 4'b0100, 4'd1);
    step(0, 4'b0000, 4'b1111, 1, 4'b0001, 4'b1111, 4'b0000, 4'd2);
    step(0, 4'b1111, 4'b1111, 0, 4'b0001, 4'b1111, 4'b1111, 4'd2);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b1111, 4'b0000, 4'd0);
    for (int k = 1; k <= 16; k++)
      step(0, 4'b0001, {3'b000, k[0]}, 1, {3'b000, k[0]}, 4'b1111, 4'b0000, 4'(k));
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b1111, 4'b0000, 4'd0);
`else
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'd0);
    step(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'd0);
    step(0, 4'b0100, 4'b1111, 0, 4'b0100, 4'b0110, 4'b0000, 4'd0);
    step(0, 4'b1000, 4'b0000, 0, 4'b0100, 4'b1110, 4'b0000, 4'd0);
    step(1, 4'b1111, 4'b1111, 0, 4'b0000, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b1111, 4'b1010, 0, 4'b1010, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b0000, 4'b0101, 1, 4'b1010, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b0101, 4'b1111, 0, 4'b1111, 4'b1111, 4'b0000, 4'd0);
    step(0, 4'b1001, 4'b0000, 1, 4'b0110, 4'b1111, 4'b0000, 4'd0);
`endif
    @(negedge CLK);
    bus.EN     = 4'b0000;
    bus.COMMIT = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
